// File: rtl/obi_sram_cut_if.sv
// obi_sram_cut_if: OBI request/response bundle shared by the upstream and downstream sides
//   req/addr/we/be/wdata : request from master to slave
//   gnt                  : slave accepts the request this cycle
//   rvalid/rdata/err     : response from slave to master
interface obi_sram_cut_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_sram_cut.sv
// obi_sram_cut: registered OBI cut in front of an SRAM window with out-of-range error responses
//   clk_i : clock, all state on the rising edge
//   rst_i : asynchronous active-high reset
//   sbr   : upstream OBI port (slave modport)
//   mgr   : downstream OBI port towards the SRAM (master modport)
module obi_sram_cut #(
    parameter int unsigned NumWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    obi_sram_cut_if.slave  sbr,
    obi_sram_cut_if.master mgr
);
    localparam logic [32:0] WinSize = 33'(4 * NumWords);
    localparam logic [3:0]  MaxOut  = 4'(MaxOutstanding);

    logic        w_in_range, w_gnt, w_rsp, w_fwd;
    logic [32:0] w_off;
    logic        r_full, r_we, r_err_pend, r_rvalid, r_rerr;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be, r_cnt;

    always_comb begin
        // 33-bit offset: an address below the base borrows into bit 32 and lands outside the window
        w_off      = {1'b0, sbr.addr} - {1'b0, BaseAddr};
        w_in_range = w_off < WinSize;
        // out-of-range requests wait for an idle cut so the error never collides with an SRAM response
        w_gnt      = ~rst_i & sbr.req & (w_in_range ? (r_cnt < MaxOut) & (~r_full | mgr.gnt)
                                                    : (r_cnt == 4'd0) & ~r_full);
        w_rsp      = r_rvalid | r_err_pend;
        // a downstream response with nothing outstanding is dropped
        w_fwd      = mgr.rvalid & (r_cnt != 4'd0);
    end

    assign sbr.gnt    = w_gnt;
    assign sbr.rvalid = w_rsp;
    assign sbr.rdata  = r_rdata;
    assign sbr.err    = r_rerr | r_err_pend;
    assign mgr.req    = r_full;
    assign mgr.addr   = r_addr;
    assign mgr.we     = r_we;
    assign mgr.be     = r_be;
    assign mgr.wdata  = r_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full     <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_err_pend <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rerr     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_gnt && w_in_range) begin
                r_full  <= 1'b1;
                r_addr  <= sbr.addr;
                r_we    <= sbr.we;
                r_be    <= sbr.be;
                r_wdata <= sbr.wdata;
            end else if (mgr.gnt) begin
                r_full  <= 1'b0;
            end
            r_err_pend <= w_gnt & ~w_in_range;
            r_rvalid   <= w_fwd;
            r_rdata    <= w_fwd ? mgr.rdata : '0;
            r_rerr     <= w_fwd & mgr.err;
            r_cnt      <= r_cnt + {3'b0, w_gnt} - {3'b0, w_rsp};
        end
    end
endmodule

// File: tb/tb_obi_sram_cut.sv
// tb_obi_sram_cut: directed self-checking bench for obi_sram_cut with a zero-wait SRAM model
module tb_obi_sram_cut;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gnt_en = 1'b1;
    logic inject = 1'b0;
    logic mrv = 1'b0;
    logic [31:0] mrd = '0;
    logic [31:0] mem [0:1023];
    int n_checks = 0;
    int n_errs = 0;

    obi_sram_cut_if sbr_if();
    obi_sram_cut_if mgr_if();

    obi_sram_cut #(.NumWords(1024), .BaseAddr(32'h0), .MaxOutstanding(4)) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .sbr(sbr_if),
        .mgr(mgr_if)
    );

    always #5 clk = ~clk;

    // zero-wait SRAM: grant follows gnt_en, response one cycle after the handshake
    assign mgr_if.gnt    = gnt_en;
    assign mgr_if.rvalid = mrv | inject;
    assign mgr_if.rdata  = mrv ? mrd : 32'h0;
    assign mgr_if.err    = 1'b0;

    always @(posedge clk) begin
        mrv <= mgr_if.req && gnt_en;
        mrd <= 32'h0;
        if (mgr_if.req && gnt_en) begin
            if (mgr_if.we) begin
                for (int b = 0; b < 4; b++)
                    if (mgr_if.be[b]) mem[mgr_if.addr[11:2]][8*b +: 8] <= mgr_if.wdata[8*b +: 8];
            end else begin
                mrd <= mem[mgr_if.addr[11:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp, input logic exp_err);
        bit v = 1'b0;
        for (int k = 0; k < 20 && !v; k++) begin
            if (sbr_if.rvalid) begin
                v = 1'b1;
                check({tag, "_rdata"}, sbr_if.rdata, exp);
                check({tag, "_err"}, 32'(sbr_if.err), 32'(exp_err));
            end
            tick;
        end
        check({tag, "_rvalid"}, 32'(v), 32'd1);
    endtask

    task automatic issue(input string tag, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        bit g = 1'b0;
        sbr_if.req = 1'b1;
        sbr_if.addr = a;
        sbr_if.we = we;
        sbr_if.be = be;
        sbr_if.wdata = wd;
        for (int k = 0; k < 20 && !g; k++) begin
            #1;
            g = sbr_if.gnt;
            tick;
        end
        sbr_if.req = 1'b0;
        check({tag, "_gnt"}, 32'(g), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        issue("wr", a, 1'b1, be, wd);
        wait_rsp("wr", 32'h0, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        issue("rd", a, 1'b0, 4'hF, 32'h0);
        wait_rsp("rd", exp, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b2b_exp [4];
        int grants;
        b2b_exp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        sbr_if.req = 1'b1;
        sbr_if.addr = 32'h14;
        sbr_if.we = 1'b0;
        sbr_if.be = 4'hF;
        sbr_if.wdata = 32'h0;
        #2;
        check("rst_gnt", 32'(sbr_if.gnt), 32'd0);
        check("rst_rvalid", 32'(sbr_if.rvalid), 32'd0);
        check("rst_err", 32'(sbr_if.err), 32'd0);
        check("rst_rdata", sbr_if.rdata, 32'h0);
        check("rst_mreq", 32'(mgr_if.req), 32'd0);
        tick;
        tick;
        check("rst_gnt_held", 32'(sbr_if.gnt), 32'd0);
        rst = 1'b0;
        sbr_if.req = 1'b0;
        #1;
        check("rel_rvalid", 32'(sbr_if.rvalid), 32'd0);
        check("rel_mreq", 32'(mgr_if.req), 32'd0);
        tick;

        do_write(32'h00, 4'hF, 32'h1111_1111);
        do_write(32'h04, 4'hF, 32'h2222_2222);
        do_write(32'h08, 4'hF, 32'h3333_3333);
        do_write(32'h0C, 4'hF, 32'h4444_4444);
        do_write(32'h10, 4'hF, 32'h5555_5555);
        do_write(32'h14, 4'hF, 32'hCAFE_F00D);
        do_write(32'h20, 4'hF, 32'hAAAA_AAAA);

        // single read, exact latency
        sbr_if.req = 1'b1;
        sbr_if.addr = 32'h14;
        sbr_if.we = 1'b0;
        sbr_if.be = 4'hF;
        #1;
        check("one_gnt", 32'(sbr_if.gnt), 32'd1);
        tick;
        sbr_if.req = 1'b0;
        check("one_mreq", 32'(mgr_if.req), 32'd1);
        check("one_maddr", mgr_if.addr, 32'h14);
        check("one_mwe", 32'(mgr_if.we), 32'd0);
        tick;
        check("one_early", 32'(sbr_if.rvalid), 32'd0);
        tick;
        check("one_rvalid", 32'(sbr_if.rvalid), 32'd1);
        check("one_rdata", sbr_if.rdata, 32'hCAFE_F00D);
        check("one_err", 32'(sbr_if.err), 32'd0);
        tick;
        check("one_after", 32'(sbr_if.rvalid), 32'd0);
        check("one_rdata0", sbr_if.rdata, 32'h0);

        // back-to-back reads at full throughput
        for (int i = 0; i < 7; i++) begin
            sbr_if.req = i < 4;
            sbr_if.addr = 32'(4 * i);
            #1;
            if (i < 4) check("b2b_gnt", 32'(sbr_if.gnt), 32'd1);
            check("b2b_rvalid", 32'(sbr_if.rvalid), 32'(i >= 3));
            if (i >= 3) check("b2b_rdata", sbr_if.rdata, b2b_exp[i-3]);
            tick;
        end
        sbr_if.req = 1'b0;

        // downstream stall: one accept, held payload stable
        gnt_en = 1'b0;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            sbr_if.req = 1'b1;
            sbr_if.addr = (i == 0) ? 32'h10 : 32'h18;
            #1;
            grants += int'(sbr_if.gnt);
            if (i > 0) begin
                check("stall_mreq", 32'(mgr_if.req), 32'd1);
                check("stall_maddr", mgr_if.addr, 32'h10);
            end
            tick;
        end
        check("stall_grants", 32'(grants), 32'd1);
        sbr_if.req = 1'b0;
        gnt_en = 1'b1;
        wait_rsp("stall", 32'h5555_5555, 1'b0);

        // out-of-range request behind two outstanding reads
        sbr_if.req = 1'b1;
        sbr_if.addr = 32'h0;
        #1;
        check("oor_g0", 32'(sbr_if.gnt), 32'd1);
        tick;
        sbr_if.addr = 32'h4;
        #1;
        check("oor_g1", 32'(sbr_if.gnt), 32'd1);
        tick;
        sbr_if.addr = 32'h1000;
        #1;
        check("oor_wait0", 32'(sbr_if.gnt), 32'd0);
        tick;
        check("oor_wait1", 32'(sbr_if.gnt), 32'd0);
        check("oor_rd0", sbr_if.rdata, 32'h1111_1111);
        tick;
        check("oor_wait2", 32'(sbr_if.gnt), 32'd0);
        check("oor_rd1", sbr_if.rdata, 32'h2222_2222);
        tick;
        check("oor_gnt", 32'(sbr_if.gnt), 32'd1);
        check("oor_mreq", 32'(mgr_if.req), 32'd0);
        tick;
        sbr_if.req = 1'b0;
        check("oor_rvalid", 32'(sbr_if.rvalid), 32'd1);
        check("oor_err", 32'(sbr_if.err), 32'd1);
        check("oor_rdata", sbr_if.rdata, 32'h0);
        check("oor_mreq2", 32'(mgr_if.req), 32'd0);
        tick;
        check("oor_done", 32'(sbr_if.rvalid), 32'd0);
        check("oor_err0", 32'(sbr_if.err), 32'd0);

        // stray downstream response while idle
        inject = 1'b1;
        tick;
        inject = 1'b0;
        check("stray_rv0", 32'(sbr_if.rvalid), 32'd0);
        tick;
        check("stray_rv1", 32'(sbr_if.rvalid), 32'd0);
        do_read(32'h14, 32'hCAFE_F00D);

        // partial writes
        do_write(32'h20, 4'b0011, 32'h1234_5678);
        do_read(32'h20, 32'hAAAA_5678);
        do_write(32'h20, 4'b1000, 32'hDEAD_BEEF);
        do_read(32'h20, 32'hDEAA_5678);

        // reset with one request held and one response in flight
        sbr_if.req = 1'b1;
        sbr_if.addr = 32'h0;
        #1;
        check("mid_g0", 32'(sbr_if.gnt), 32'd1);
        tick;
        sbr_if.addr = 32'h4;
        #1;
        check("mid_g1", 32'(sbr_if.gnt), 32'd1);
        tick;
        gnt_en = 1'b0;
        sbr_if.addr = 32'h14;
        check("mid_held", 32'(mgr_if.req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_gnt", 32'(sbr_if.gnt), 32'd0);
        check("mid_rvalid", 32'(sbr_if.rvalid), 32'd0);
        check("mid_rdata", sbr_if.rdata, 32'h0);
        check("mid_err", 32'(sbr_if.err), 32'd0);
        check("mid_mreq", 32'(mgr_if.req), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        sbr_if.req = 1'b0;
        gnt_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_stray", 32'(sbr_if.rvalid), 32'd0);
            tick;
        end
        do_read(32'h14, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
